qam16_frame_mapper: RTL and testbench
=====================================

# qam16_frame_mapper

Transmit-side counterpart of the QAM-16 receive chain. Accepts 4-bit symbols over a valid/ready handshake and maps them to Gray-coded I/Q amplitude levels. Prepends each frame with the pilot that the receiver's pilot-cut stage strips. Emits one oversampled I/Q sample per clock for the transmit carrier multipliers and shaping filters.

## Interface
- width_data, 16, signed I/Q output width
- AMP, 4096, unit amplitude; levels are ±AMP and ±3·AMP, and 3·AMP must fit in signed width_data
- PILOT_LEN, 10, pilot samples per frame
- SYM_PER_FRAME, 64, data symbols per frame (≥1)
- SPS, 4, output samples per symbol (≥2)
- COUNT_WIDTH, 8, counter width; must hold max(PILOT_LEN, SYM_PER_FRAME, SPS)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  frame request; sampled only in IDLE
- sym_in  in  4  symbol; [3:2] selects I, [1:0] selects Q
- sym_valid  in  1  sym_in valid
- sym_ready  out  1  symbol consumed this cycle
- data_out_I  out  width_data  signed I sample, registered
- data_out_Q  out  width_data  signed Q sample, registered
- out_valid  out  1  data_out_I/Q valid
- frame_start  out  1  high on the first pilot sample only
- busy  out  1  frame in progress
- underrun  out  1  sticky flag: a symbol slot had no valid symbol

## Operation
- Gray map per axis: 00→−3·AMP, 01→−AMP, 11→+AMP, 10→+3·AMP. Values are two's complement.
- Pilot sample: I = Q = +3·AMP.
- FSM states:
  - IDLE: outputs 0, out_valid=0. start=1 → PILOT.
  - PILOT: pilot_cnt counts 0..PILOT_LEN−1 → DATA.
  - DATA: sym_cnt counts 0..SYM_PER_FRAME−1, phase counts 0..SPS−1. After the last sample of the last symbol → IDLE.
- sym_ready is asserted combinationally in exactly these cycles:
  - the last PILOT cycle;
  - phase=SPS−1 of every data symbol except the last.
  Both cases require state≠IDLE and rst=0.
- Load cycle with sym_valid=1: the symbol is registered and mapped, then held for SPS output samples.
- Load cycle with sym_valid=0: the slot still elapses (SPS samples of I=Q=0) and underrun is set. The frame length never changes.
- underrun clears on reset and on an accepted start.
- busy = (state≠IDLE).

## Timing
- Reset: state IDLE, all counters 0, all outputs 0 (sym_ready 0, out_valid 0, frame_start 0, busy 0, underrun 0).
- Reset mid-frame aborts the frame; outputs are 0 in the cycle after rst is sampled high. rst has priority over start.
- Let start be sampled high at edge t:
  - pilot appears on the outputs for cycles t+1..t+PILOT_LEN, with frame_start=1 at t+1;
  - sym_ready=1 in cycle t+PILOT_LEN;
  - symbol k occupies cycles t+PILOT_LEN+1+k·SPS .. t+PILOT_LEN+(k+1)·SPS.
- Frame length is exactly PILOT_LEN + SYM_PER_FRAME·SPS cycles, with out_valid continuous (no gaps).
- out_valid drops in the cycle after the last data sample.
- A start in that cycle (state is IDLE) is accepted, giving one idle cycle between frames.
- start while busy is ignored and is not queued.
- Counter wrap: phase and sym_cnt reset to 0 on frame end. No counter ever wraps inside a frame.

## Structure
- Package qam_tx_pkg holds:
  - the state enum (IDLE, PILOT, DATA);
  - Gray level encodings;
  - the function level(2-bit, AMP) → signed width_data.
- Sub-module qam16_mapper is purely combinational: sym_in[3:0] → I/Q levels. It is instantiated once inside the FSM block.
- The output register stage and counters live in qam16_frame_mapper.

## Test plan
- Reset/idle: hold rst 3 cycles, then start=0 for 20 cycles → all outputs 0, busy=0.
- Single frame with defaults: pulse start; sym_valid always 1, symbols cycling 0x0..0xF →
  - 10 samples of I=Q=12288, then 256 samples;
  - symbol 0x6 gives I=−4096, Q=+12288 for 4 cycles;
  - out_valid high for exactly 266 cycles.
- Underrun: drop sym_valid for symbol 5 only → symbol-5 slot emits I=Q=0 for 4 cycles, underrun=1 from then on, frame still 266 cycles; the next start clears underrun.
- Back-to-back: start held high continuously → frames separated by exactly one out_valid=0 cycle; starts during busy are ignored.
- Reset mid-frame: assert rst during DATA symbol 30 → outputs 0 in the next cycle, busy=0, and a new start produces a full pilot.
- Boundary parameters: SPS=2, SYM_PER_FRAME=1, PILOT_LEN=1 → sym_ready only in the pilot cycle, frame length 3.

Source files
------------

// File: rtl/qam_tx_pkg.sv
// qam_tx_pkg
//   Shared types and helpers for the QAM-16 transmit frame mapper.
//   - state_t   : frame FSM states (IDLE, PILOT, DATA)
//   - GRAY_*    : 2-bit Gray codes for the four amplitude levels per axis
//   - level()   : Gray code -> signed amplitude (-3A, -A, +A, +3A)
package qam_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PILOT = 2'd1,
      DATA  = 2'd2
   } state_t;

   // Gray order along the axis: 00, 01, 11, 10 from most negative to most positive
   localparam logic [1:0] GRAY_NEG3 = 2'b00;
   localparam logic [1:0] GRAY_NEG1 = 2'b01;
   localparam logic [1:0] GRAY_POS1 = 2'b11;
   localparam logic [1:0] GRAY_POS3 = 2'b10;

   // Returned at full 32-bit precision; callers size it to their sample width,
   // which is lossless as long as 3*amp fits that width.
   function automatic int level(input logic [1:0] code, input int amp);
      case (code)
         GRAY_NEG3: level = -(32'sd3 * amp);
         GRAY_NEG1: level = -amp;
         GRAY_POS1: level = amp;
         GRAY_POS3: level = 32'sd3 * amp;
         default:   level = 32'sd0;
      endcase
   endfunction

endpackage

// File: rtl/qam16_mapper.sv
// qam16_mapper
//   Purely combinational QAM-16 symbol mapper.
//   Ports:
//     sym_in  [3:0]           symbol; [3:2] selects the I level, [1:0] the Q level
//     level_i [width_data-1:0] signed I amplitude
//     level_q [width_data-1:0] signed Q amplitude
module qam16_mapper
   import qam_tx_pkg::*;
#(
   parameter int width_data = 16,
   parameter int AMP        = 4096
)
(
   input  logic        [3:0]            sym_in,
   output logic signed [width_data-1:0] level_i,
   output logic signed [width_data-1:0] level_q
);

   assign level_i = width_data'(level(sym_in[3:2], AMP));
   assign level_q = width_data'(level(sym_in[1:0], AMP));

endmodule

// File: rtl/qam16_frame_mapper.sv
// qam16_frame_mapper
//   Framed QAM-16 transmit mapper: on start, emits PILOT_LEN pilot samples
//   (I = Q = +3*AMP) followed by SYM_PER_FRAME symbols, each held for SPS
//   samples. One registered I/Q sample per clock, out_valid gap-free per frame.
//   Ports:
//     clk, rst               clock, synchronous active-high reset
//     start                  frame request, honoured only while idle
//     sym_in, sym_valid      symbol input; consumed in cycles where sym_ready=1
//     sym_ready              combinational: a symbol is taken this cycle
//     data_out_I/Q           registered signed I/Q sample
//     out_valid              sample valid
//     frame_start            high on the first pilot sample
//     busy                   frame in progress
//     underrun               sticky: a symbol slot found sym_valid low
module qam16_frame_mapper
   import qam_tx_pkg::*;
#(
   parameter int width_data    = 16,
   parameter int AMP           = 4096,
   parameter int PILOT_LEN     = 10,
   parameter int SYM_PER_FRAME = 64,
   parameter int SPS           = 4,
   parameter int COUNT_WIDTH   = 8
)
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic        [3:0]            sym_in,
   input  logic                         sym_valid,
   output logic                         sym_ready,
   output logic signed [width_data-1:0] data_out_I,
   output logic signed [width_data-1:0] data_out_Q,
   output logic                         out_valid,
   output logic                         frame_start,
   output logic                         busy,
   output logic                         underrun
);

   localparam logic [COUNT_WIDTH-1:0] PILOT_LAST = COUNT_WIDTH'(PILOT_LEN - 1);
   localparam logic [COUNT_WIDTH-1:0] SYM_LAST   = COUNT_WIDTH'(SYM_PER_FRAME - 1);
   localparam logic [COUNT_WIDTH-1:0] PHASE_LAST = COUNT_WIDTH'(SPS - 1);
   localparam logic signed [width_data-1:0] PILOT_LVL = width_data'(level(GRAY_POS3, AMP));
   localparam logic signed [width_data-1:0] ZERO_LVL  = {width_data{1'b0}};

   state_t                        state_r;
   logic [COUNT_WIDTH-1:0]        pilot_cnt_r;
   logic [COUNT_WIDTH-1:0]        sym_cnt_r;
   logic [COUNT_WIDTH-1:0]        phase_r;
   logic signed [width_data-1:0]  data_i_r;
   logic signed [width_data-1:0]  data_q_r;
   logic                          out_valid_r;
   logic                          frame_start_r;
   logic                          busy_r;
   logic                          underrun_r;

   logic signed [width_data-1:0]  map_i_s;
   logic signed [width_data-1:0]  map_q_s;
   logic signed [width_data-1:0]  load_i_s;
   logic signed [width_data-1:0]  load_q_s;
   logic                          pilot_last_s;
   logic                          phase_last_s;
   logic                          sym_last_s;
   logic                          sym_ready_s;

   qam16_mapper #(
      .width_data (width_data),
      .AMP        (AMP)
   ) u_mapper (
      .sym_in  (sym_in),
      .level_i (map_i_s),
      .level_q (map_q_s)
   );

   assign pilot_last_s = (pilot_cnt_r == PILOT_LAST);
   assign phase_last_s = (phase_r == PHASE_LAST);
   assign sym_last_s   = (sym_cnt_r == SYM_LAST);

   // Load slots: last pilot cycle, and the final phase of every symbol but the last
   always_comb begin
      sym_ready_s = 1'b0;
      if (rst) begin
         sym_ready_s = 1'b0;
      end else if (state_r == PILOT) begin
         sym_ready_s = pilot_last_s;
      end else if (state_r == DATA) begin
         sym_ready_s = phase_last_s && !sym_last_s;
      end else begin
         sym_ready_s = 1'b0;
      end
   end

   // Value captured in a load slot: the mapped symbol, or silence when none is offered
   always_comb begin
      load_i_s = ZERO_LVL;
      load_q_s = ZERO_LVL;
      if (sym_valid) begin
         load_i_s = map_i_s;
         load_q_s = map_q_s;
      end else begin
         load_i_s = ZERO_LVL;
         load_q_s = ZERO_LVL;
      end
   end

   // Frame FSM, counters and registered output stage
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         pilot_cnt_r   <= '0;
         sym_cnt_r     <= '0;
         phase_r       <= '0;
         data_i_r      <= ZERO_LVL;
         data_q_r      <= ZERO_LVL;
         out_valid_r   <= 1'b0;
         frame_start_r <= 1'b0;
         busy_r        <= 1'b0;
         underrun_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r       <= PILOT;
                  pilot_cnt_r   <= '0;
                  data_i_r      <= PILOT_LVL;
                  data_q_r      <= PILOT_LVL;
                  out_valid_r   <= 1'b1;
                  frame_start_r <= 1'b1;
                  busy_r        <= 1'b1;
                  underrun_r    <= 1'b0;
               end else begin
                  data_i_r      <= ZERO_LVL;
                  data_q_r      <= ZERO_LVL;
                  out_valid_r   <= 1'b0;
                  frame_start_r <= 1'b0;
                  busy_r        <= 1'b0;
               end
            end
            PILOT: begin
               frame_start_r <= 1'b0;
               if (pilot_last_s) begin
                  // Symbol 0 is loaded here so data follows the pilot without a gap
                  state_r     <= DATA;
                  pilot_cnt_r <= '0;
                  sym_cnt_r   <= '0;
                  phase_r     <= '0;
                  data_i_r    <= load_i_s;
                  data_q_r    <= load_q_s;
                  if (!sym_valid) begin
                     underrun_r <= 1'b1;
                  end
               end else begin
                  pilot_cnt_r <= pilot_cnt_r + 1'b1;
               end
            end
            DATA: begin
               if (phase_last_s) begin
                  if (sym_last_s) begin
                     state_r     <= IDLE;
                     sym_cnt_r   <= '0;
                     phase_r     <= '0;
                     data_i_r    <= ZERO_LVL;
                     data_q_r    <= ZERO_LVL;
                     out_valid_r <= 1'b0;
                     busy_r      <= 1'b0;
                  end else begin
                     sym_cnt_r <= sym_cnt_r + 1'b1;
                     phase_r   <= '0;
                     data_i_r  <= load_i_s;
                     data_q_r  <= load_q_s;
                     if (!sym_valid) begin
                        underrun_r <= 1'b1;
                     end
                  end
               end else begin
                  phase_r <= phase_r + 1'b1;
               end
            end
            default: begin
               state_r       <= IDLE;
               pilot_cnt_r   <= '0;
               sym_cnt_r     <= '0;
               phase_r       <= '0;
               data_i_r      <= ZERO_LVL;
               data_q_r      <= ZERO_LVL;
               out_valid_r   <= 1'b0;
               frame_start_r <= 1'b0;
               busy_r        <= 1'b0;
            end
         endcase
      end
   end

   assign sym_ready   = sym_ready_s;
   assign data_out_I  = data_i_r;
   assign data_out_Q  = data_q_r;
   assign out_valid   = out_valid_r;
   assign frame_start = frame_start_r;
   assign busy        = busy_r;
   assign underrun    = underrun_r;

endmodule

// File: tb/tb_qam16_frame_mapper.sv
// tb_qam16_frame_mapper
//   Self-checking bench for qam16_frame_mapper. A default-parameter instance is
//   driven with random symbols and checked every cycle against a frame model
//   (position within the frame -> expected sample); a second instance with
//   PILOT_LEN=1, SYM_PER_FRAME=1, SPS=2 gets a short directed check.
module tb_qam16_frame_mapper;

   localparam int PL        = 10;
   localparam int SPF       = 64;
   localparam int SPS       = 4;
   localparam int AMP       = 4096;
   localparam int FRAME_LEN = PL + SPF * SPS;

   logic               clk;
   logic               rst;
   logic               start;
   logic [3:0]         sym_in;
   logic               sym_valid;
   logic               sym_ready;
   logic signed [15:0] data_out_I;
   logic signed [15:0] data_out_Q;
   logic               out_valid;
   logic               frame_start;
   logic               busy;
   logic               underrun;

   logic               start_b;
   logic [3:0]         sym_in_b;
   logic               sym_valid_b;
   logic               sym_ready_b;
   logic signed [15:0] i_b;
   logic signed [15:0] q_b;
   logic               ov_b;
   logic               fs_b;
   logic               busy_b;
   logic               und_b;

   qam16_frame_mapper #(
      .width_data(16), .AMP(AMP), .PILOT_LEN(PL), .SYM_PER_FRAME(SPF), .SPS(SPS), .COUNT_WIDTH(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .sym_in(sym_in), .sym_valid(sym_valid),
      .sym_ready(sym_ready), .data_out_I(data_out_I), .data_out_Q(data_out_Q),
      .out_valid(out_valid), .frame_start(frame_start), .busy(busy), .underrun(underrun)
   );

   qam16_frame_mapper #(
      .width_data(16), .AMP(AMP), .PILOT_LEN(1), .SYM_PER_FRAME(1), .SPS(2), .COUNT_WIDTH(8)
   ) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .sym_in(sym_in_b), .sym_valid(sym_valid_b),
      .sym_ready(sym_ready_b), .data_out_I(i_b), .data_out_Q(q_b),
      .out_valid(ov_b), .frame_start(fs_b), .busy(busy_b), .underrun(und_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // model state: frame position of the current cycle (-1 = idle)
   int         pos = -1;
   logic       und_exp = 1'b0;
   int         mode = 0;
   logic [3:0] sym_tab [SPF];
   logic       valid_tab [SPF];
   logic       nxt_rst = 1'b1;
   logic       nxt_start = 1'b0;
   logic       nxt_start_b = 1'b0;
   int         ov_cnt;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Gray level: 00 -> -3A, 01 -> -A, 10 -> +3A, 11 -> +A
   function automatic int ref_level(input logic [1:0] code);
      int tab [4];
      tab = '{-3, -1, 3, 1};
      return tab[code] * AMP;
   endfunction

   task automatic new_tables();
      for (int i = 0; i < SPF; i++) begin
         sym_tab[i]   = (mode == 0) ? 4'(i % 16) : 4'($urandom_range(15));
         valid_tab[i] = (mode == 3) ? ($urandom_range(3) != 0) : !(mode == 2 && i == 5);
      end
   endtask

   // one clock: advance the model over the edge, apply next inputs, check outputs
   task automatic tick();
      int m;
      int k;
      int d;
      int exp_i;
      int exp_q;
      logic exp_rdy;
      @(posedge clk);
      #1;
      if (rst) begin
         pos = -1;
         und_exp = 1'b0;
      end else if (pos < 0) begin
         if (start) begin
            pos = 0;
            und_exp = 1'b0;
            new_tables();
         end
      end else begin
         pos++;
         if (pos == FRAME_LEN) pos = -1;
      end
      if (pos >= PL && (pos - PL) % SPS == 0 && !valid_tab[(pos - PL) / SPS]) und_exp = 1'b1;

      rst   = nxt_rst;
      start = nxt_start;
      m = (pos < PL) ? 0 : (pos - PL + 1) / SPS;
      if (m >= SPF) m = SPF - 1;
      sym_in      = sym_tab[m];
      sym_valid   = valid_tab[m];
      start_b     = nxt_start_b;
      sym_in_b    = 4'h6;
      sym_valid_b = 1'b1;
      #1;

      exp_rdy = 1'b0;
      if (!rst && pos >= PL - 1) begin
         d = pos - (PL - 1);
         if (d % SPS == 0 && d / SPS < SPF) exp_rdy = 1'b1;
      end
      if (pos < 0) begin
         exp_i = 0;
         exp_q = 0;
      end else if (pos < PL) begin
         exp_i = 3 * AMP;
         exp_q = 3 * AMP;
      end else begin
         k = (pos - PL) / SPS;
         exp_i = valid_tab[k] ? ref_level(sym_tab[k][3:2]) : 0;
         exp_q = valid_tab[k] ? ref_level(sym_tab[k][1:0]) : 0;
      end
      chk("data_I", data_out_I, exp_i);
      chk("data_Q", data_out_Q, exp_q);
      chk("out_valid", out_valid, (pos >= 0) ? 1 : 0);
      chk("frame_start", frame_start, (pos == 0) ? 1 : 0);
      chk("busy", busy, (pos >= 0) ? 1 : 0);
      chk("underrun", underrun, und_exp);
      chk("sym_ready", sym_ready, exp_rdy);
   endtask

   task automatic run_frame(input int m);
      mode = m;
      nxt_start = 1'b1;
      tick();
      nxt_start = 1'b0;
      ov_cnt = 0;
      repeat (FRAME_LEN + 3) begin
         tick();
         if (out_valid) ov_cnt++;
      end
   endtask

   initial begin
      int gaps;
      rst = 1'b1; start = 1'b0; sym_in = 4'h0; sym_valid = 1'b0;
      start_b = 1'b0; sym_in_b = 4'h0; sym_valid_b = 1'b0;
      for (int i = 0; i < SPF; i++) begin
         sym_tab[i] = 4'h0;
         valid_tab[i] = 1'b1;
      end

      // reset, then a quiet idle period
      nxt_rst = 1'b1;
      repeat (3) tick();
      nxt_rst = 1'b0;
      repeat (20) tick();

      // single frame, symbols cycling 0x0..0xF, all valid
      run_frame(0);
      chk("frame_len_cycling", ov_cnt, FRAME_LEN);

      // symbol 5 slot starved
      run_frame(2);
      chk("frame_len_underrun", ov_cnt, FRAME_LEN);
      chk("underrun_sticky", underrun, 1);

      // next frame clears underrun (model checks the first cycle too)
      run_frame(1);
      chk("underrun_cleared", underrun, 0);

      // back-to-back with start held high, random sym_valid drops
      mode = 3;
      nxt_start = 1'b1;
      tick();
      gaps = 0;
      repeat (3 * (FRAME_LEN + 1)) begin
         tick();
         if (!out_valid) gaps++;
      end
      nxt_start = 1'b0;
      chk("b2b_gaps", gaps, 3);
      repeat (FRAME_LEN + 2) tick();

      // reset during data symbol 30, then a fresh full frame
      mode = 1;
      nxt_start = 1'b1;
      tick();
      nxt_start = 1'b0;
      repeat (PL + 30 * SPS + 1) tick();
      nxt_rst = 1'b1;
      tick();
      nxt_rst = 1'b0;
      repeat (3) tick();
      run_frame(1);
      chk("frame_len_after_rst", ov_cnt, FRAME_LEN);

      // boundary instance: PILOT_LEN=1, SYM_PER_FRAME=1, SPS=2
      nxt_start_b = 1'b1;
      tick();
      chk("b_idle_ready", sym_ready_b, 0);
      chk("b_idle_busy", busy_b, 0);
      nxt_start_b = 1'b0;
      tick();
      chk("b_pilot_I", i_b, 3 * AMP);
      chk("b_pilot_Q", q_b, 3 * AMP);
      chk("b_pilot_fs", fs_b, 1);
      chk("b_pilot_ready", sym_ready_b, 1);
      chk("b_pilot_valid", ov_b, 1);
      ov_cnt = 1;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("b_data_I", i_b, -AMP);
         chk("b_data_Q", q_b, 3 * AMP);
         chk("b_data_ready", sym_ready_b, 0);
         chk("b_data_fs", fs_b, 0);
         if (ov_b) ov_cnt++;
      end
      tick();
      chk("b_frame_len", ov_cnt, 3);
      chk("b_end_valid", ov_b, 0);
      chk("b_end_busy", busy_b, 0);
      chk("b_end_I", i_b, 0);
      chk("b_underrun", und_b, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
